// File: rtl/imem_loader.sv
// imem_loader
//   Parametrised instruction memory with a built-in program loader.
//   A host streams a program in over a valid/ready load port. Once the
//   program is resident the core fetches words over a registered read
//   port with 1-cycle latency. Every read result carries a valid strobe
//   and an out-of-range error flag. Unused outputs are driven to zero
//   rather than left floating.
//
// Parameters
//   DATA_W : instruction word width in bits
//   ADDR_W : address width in bits
//   DEPTH  : number of words, 1 <= DEPTH <= 2**ADDR_W
//
// Ports
//   clk        : clock, rising edge
//   nrst       : asynchronous active-low reset
//   load_start : request to begin a new program load (IDLE or RUN)
//   load_valid : load_data holds a word to write
//   load_last  : with load_valid, marks the final word of the program
//   load_data  : program word
//   load_ready : loader accepts a word this cycle (high only in LOAD)
//   load_done  : a program is resident and reads are enabled (RUN)
//   load_count : number of words in the resident program
//   rd_en      : fetch request
//   rd_addr    : fetch address
//   rd_data    : fetched word, registered, zero unless rd_valid
//   rd_valid   : rd_data holds the word requested in the previous cycle
//   rd_err     : the fetch requested in the previous cycle was rejected

module imem_loader #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  // Word count at which the buffer is full and the load ends on its own.
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] wptr_next;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W:0]   count_inc;
  logic              wr_en;
  logic              rd_ok;

  logic [DATA_W-1:0] mem [DEPTH];

  assign load_ready = (state == LOAD);
  assign load_done  = (state == RUN);
  assign count_inc  = load_count + 1'b1;

  // A fetch is honoured only while a program is resident and the address
  // falls inside it. Words beyond load_count may hold stale data from an
  // earlier, longer program and must stay unreachable.
  assign rd_ok = rd_en && (state == RUN) && ({1'b0, rd_addr} < load_count);

  // Loader next-state logic. load_start is only honoured from IDLE or RUN,
  // so a stray start during LOAD cannot restart a load in progress. The
  // load ends after the beat flagged last, or after the beat that fills
  // the buffer; in that case the whole program is kept.
  always_comb begin
    state_next = state;
    wptr_next  = wptr;
    count_next = load_count;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next = LOAD;
          wptr_next  = '0;
          count_next = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          wr_en      = 1'b1;
          wptr_next  = wptr + 1'b1;
          count_next = count_inc;
          if (load_last || (count_inc == FULL_COUNT)) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (load_start) begin
          state_next = LOAD;
          wptr_next  = '0;
          count_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        wptr_next  = '0;
        count_next = '0;
      end
    endcase
  end

  // Loader state, write pointer and program length.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      wptr       <= '0;
      load_count <= '0;
    end else begin
      state      <= state_next;
      wptr       <= wptr_next;
      load_count <= count_next;
    end
  end

  // Program storage. Reset clears every word so that a fresh block never
  // exposes undefined contents.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wptr] <= load_data;
    end
  end

  // Registered read port. Each request yields exactly one result cycle:
  // data with rd_valid, or zero with rd_err. No request yields zero with
  // both flags low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_err   <= rd_en && !rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_addr];
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed, table-driven bench for imem_loader. Each table record is one
//   clock cycle: the inputs driven before the rising edge and the outputs
//   expected just after it. Reset corner cases are hand-written sequences.

module tb_imem_loader;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              nrst;
  logic              load_start;
  logic              load_valid;
  logic              load_last;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;

  typedef struct {
    logic              ls;
    logic              lv;
    logic              ll;
    logic [DATA_W-1:0] ld;
    logic              re;
    logic [ADDR_W-1:0] ra;
    logic              e_ready;
    logic              e_done;
    logic [ADDR_W:0]   e_count;
    logic [DATA_W-1:0] e_data;
    logic              e_valid;
    logic              e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  imem_loader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_last (load_last),
    .load_data (load_data),
    .load_ready(load_ready),
    .load_done (load_done),
    .load_count(load_count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input int ls, input int lv, input int ll, input int ld,
                              input int re, input int ra,
                              input int er, input int ed, input int ec, input int edat,
                              input int ev, input int ee);
    vec_t v;
    v.ls      = ls[0];
    v.lv      = lv[0];
    v.ll      = ll[0];
    v.ld      = ld[DATA_W-1:0];
    v.re      = re[0];
    v.ra      = ra[ADDR_W-1:0];
    v.e_ready = er[0];
    v.e_done  = ed[0];
    v.e_count = ec[ADDR_W:0];
    v.e_data  = edat[DATA_W-1:0];
    v.e_valid = ev[0];
    v.e_err   = ee[0];
    return v;
  endfunction

  task automatic addVec(input int ls, input int lv, input int ll, input int ld,
                        input int re, input int ra,
                        input int er, input int ed, input int ec, input int edat,
                        input int ev, input int ee);
    vecs.push_back(mk(ls, lv, ll, ld, re, ra, er, ed, ec, edat, ev, ee));
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s %s: actual=0x%0h required=0x%0h", tag, field, act, req);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkField(tag, "load_ready", 32'(load_ready), 32'(v.e_ready));
    checkField(tag, "load_done",  32'(load_done),  32'(v.e_done));
    checkField(tag, "load_count", 32'(load_count), 32'(v.e_count));
    checkField(tag, "rd_data",    32'(rd_data),    32'(v.e_data));
    checkField(tag, "rd_valid",   32'(rd_valid),   32'(v.e_valid));
    checkField(tag, "rd_err",     32'(rd_err),     32'(v.e_err));
  endtask

  task automatic driveInputs(input vec_t v);
    load_start = v.ls;
    load_valid = v.lv;
    load_last  = v.ll;
    load_data  = v.ld;
    rd_en      = v.re;
    rd_addr    = v.ra;
  endtask

  // One cycle: drive on the falling edge, check 1 ns after the rising edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    driveInputs(v);
    @(posedge clk);
    #1;
    checkOutput(v, tag);
  endtask

  initial begin
    vec_t idle_v;
    vec_t zero_v;
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic 3-word program, reads, out-of-range, ignored writes in RUN,
    // read in the same cycle as a restart.
    addVec(0, 0, 0, 0,       1, 0,  0, 0, 0, 0,       0, 1);
    addVec(1, 0, 0, 0,       0, 0,  1, 0, 0, 0,       0, 0);
    addVec(0, 1, 0, 'h00001, 0, 0,  1, 0, 1, 0,       0, 0);
    addVec(0, 1, 0, 'h00002, 0, 0,  1, 0, 2, 0,       0, 0);
    addVec(0, 1, 1, 'h3FFFF, 0, 0,  0, 1, 3, 0,       0, 0);
    addVec(0, 0, 0, 0,       1, 0,  0, 1, 3, 'h00001, 1, 0);
    addVec(0, 0, 0, 0,       1, 1,  0, 1, 3, 'h00002, 1, 0);
    addVec(0, 0, 0, 0,       1, 2,  0, 1, 3, 'h3FFFF, 1, 0);
    addVec(0, 0, 0, 0,       1, 3,  0, 1, 3, 0,       0, 1);
    addVec(0, 0, 0, 0,       0, 0,  0, 1, 3, 0,       0, 0);
    addVec(0, 1, 1, 'h12345, 0, 0,  0, 1, 3, 0,       0, 0);
    addVec(0, 0, 0, 0,       1, 2,  0, 1, 3, 'h3FFFF, 1, 0);
    addVec(1, 0, 0, 0,       1, 1,  1, 0, 0, 'h00002, 1, 0);

    // Fill all 16 words without load_last; a stray start and a read during
    // LOAD are mixed in and must have no effect on the load.
    for (int k = 0; k < DEPTH; k++) begin
      addVec(k == 3, 1, 0, k, k == 5, 0,
             k < DEPTH - 1, k == DEPTH - 1, k + 1, 0, 0, k == 5);
    end
    addVec(0, 1, 0, 'h15555, 0, 0,  0, 1, 16, 0,  0, 0);
    addVec(0, 0, 0, 0,       1, 15, 0, 1, 16, 15, 1, 0);
    addVec(0, 0, 0, 0,       1, 0,  0, 1, 16, 0,  1, 0);

    // Toggling load_valid, and load_last without load_valid.
    addVec(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 7, 0, 0,  1, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 9, 0, 0,  1, 0, 1, 0, 0, 0);
    addVec(0, 1, 0, 8, 0, 0,  1, 0, 2, 0, 0, 0);
    addVec(0, 0, 1, 9, 0, 0,  1, 0, 2, 0, 0, 0);
    addVec(0, 1, 1, 6, 0, 0,  0, 1, 3, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 1,  0, 1, 3, 8, 1, 0);
    addVec(0, 0, 0, 0, 1, 2,  0, 1, 3, 6, 1, 0);
    addVec(0, 0, 0, 0, 1, 3,  0, 1, 3, 0, 0, 1);

    // Re-load a single word; the stale word at address 1 is unreachable.
    addVec(1, 0, 0, 0,       0, 0,  1, 0, 0, 0,       0, 0);
    addVec(0, 1, 1, 'h00AAA, 0, 0,  0, 1, 1, 0,       0, 0);
    addVec(0, 0, 0, 0,       1, 0,  0, 1, 1, 'h00AAA, 1, 0);
    addVec(0, 0, 0, 0,       1, 1,  0, 1, 1, 0,       0, 1);

    // Reset state.
    driveInputs(idle_v);
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput(idle_v, "reset");
    @(negedge clk);
    nrst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset between clock edges after 2 of 5 beats.
    applyStimulus(mk(1, 0, 0, 0,     0, 0,  1, 0, 0, 0, 0, 0), "mid_start");
    applyStimulus(mk(0, 1, 0, 'h111, 0, 0,  1, 0, 1, 0, 0, 0), "mid_beat0");
    applyStimulus(mk(0, 1, 0, 'h222, 0, 0,  1, 0, 2, 0, 0, 0), "mid_beat1");
    #2;
    load_data = 'h333;
    nrst = 1'b0;
    #1;
    checkOutput(idle_v, "async_reset");
    @(negedge clk);
    driveInputs(idle_v);
    nrst = 1'b1;
    applyStimulus(idle_v, "after_reset");
    applyStimulus(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1), "after_reset_read");

    // Full load of zeros, then reads across the range return zero.
    applyStimulus(mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0), "zero_start");
    for (int k = 0; k < DEPTH; k++) begin
      zero_v = mk(0, 1, 0, 0, 0, 0, k < DEPTH - 1, k == DEPTH - 1, k + 1, 0, 0, 0);
      applyStimulus(zero_v, $sformatf("zero_beat%0d", k));
    end
    applyStimulus(mk(0, 0, 0, 0, 1, 0,  0, 1, 16, 0, 1, 0), "zero_rd0");
    applyStimulus(mk(0, 0, 0, 0, 1, 7,  0, 1, 16, 0, 1, 0), "zero_rd7");
    applyStimulus(mk(0, 0, 0, 0, 1, 15, 0, 1, 16, 0, 1, 0), "zero_rd15");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Parametrised instruction memory with a built-in program-loader state machine, the next generation of the calculator's instruction store. A host streams a program in over a valid/ready load port; the core then fetches words over a registered read port with 1-cycle latency, a valid strobe and an out-of-range error flag. Width and depth are generic. Tri-state outputs are replaced by a defined zero value plus valid/error qualifiers.

Parameters:
DATA_W, 18, instruction word width in bits
ADDR_W, 4, address width in bits
DEPTH, 16, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
load_start  input  1  request to begin a new program load
load_valid  input  1  load_data holds a word to write
load_last  input  1  qualifies load_valid: this is the final word
load_data  input  DATA_W  program word
load_ready  output  1  loader accepts a word this cycle
load_done  output  1  a program is resident and reads are enabled
load_count  output  ADDR_W+1  number of words in the resident program
rd_en  input  1  fetch request
rd_addr  input  ADDR_W  fetch address
rd_data  output  DATA_W  fetched word, registered
rd_valid  output  1  rd_data is valid this cycle
rd_err  output  1  the previous-cycle fetch was rejected

Behaviour:
- The clock port is clk. The reset port is nrst. Reset is asynchronous and active-low. All state is clocked on the rising edge of clk.
- Reset values:
  - FSM goes to IDLE.
  - All memory words are 0.
  - Write pointer is 0 and load_count is 0.
  - load_ready, load_done, rd_valid and rd_err are 0.
  - rd_data is 0.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: load_start=1 moves to LOAD next cycle, with write pointer cleared.
  - LOAD: load_ready=1 combinationally. A beat is a cycle with load_valid & load_ready. Each beat writes load_data to mem[wptr] and increments wptr and load_count.
  - LOAD exits to RUN after the beat with load_last=1.
  - LOAD also exits to RUN after the beat that brings load_count to DEPTH. The buffer is full; the whole program is kept.
  - RUN: load_done=1. load_start=1 returns to LOAD and clears wptr and load_count. Memory contents are not cleared; stale words beyond the new load_count are unreachable.
- load_start while already in LOAD is ignored.
- load_valid while not in LOAD is ignored, with no write.
- load_last without load_valid has no effect.
- Read path (evaluated every cycle):
  - In RUN with rd_en=1 and rd_addr < load_count: next cycle rd_data=mem[rd_addr], rd_valid=1, rd_err=0.
  - rd_en=1 in IDLE or LOAD, or with rd_addr >= load_count: next cycle rd_data=0, rd_valid=0, rd_err=1.
  - rd_en=0: next cycle rd_data=0, rd_valid=0, rd_err=0.
- rd_valid and rd_err are single-cycle pulses per request. Back-to-back reads give one result per cycle.
- Read and load never overlap: reads are only legal in RUN and writes only occur in LOAD. A read issued in the same cycle that RUN sees load_start still completes normally, because the FSM is still in RUN that cycle.
- Reset mid-load returns the block to reset values immediately. A partial program is discarded and load_count reads 0.
- load_count saturates at DEPTH; wptr never wraps within a load.

Test Plan:
- Reset then rd_en=1, rd_addr=0 -> next cycle rd_err=1, rd_valid=0, rd_data=0; load_done=0.
- load_start, then 3 beats 18'h00001, 18'h00002, 18'h3FFFF with load_last on the third -> load_count=3, load_done=1; reads of addr 0/1/2 return 1/2/3FFFF with rd_valid pulses; read of addr 3 -> rd_err=1.
- Load 16 words 0..15 without load_last -> FSM enters RUN after beat 16 and load_count=16; a 17th load_valid writes nothing; reading addr 15 -> 15.
- Beats with load_valid toggling 1,0,1,0 -> only the asserted cycles write; wptr advances by 2.
- In RUN, re-load with 1 word 18'h00AAA -> load_count=1; addr 0 -> 18'h00AAA; addr 1 -> rd_err=1 despite the stale word.
- Drop nrst low after 2 of 5 beats, asynchronously between clock edges -> outputs clear at once; after release, load_count=0, load_done=0 and memory reads 0 after the next full load of zeros.
